// File: rtl/alu_op_sequencer.sv
// Command-side driver for a combinational ALU: one instruction per handshake,
// register-file operand fetch, condition check on NZCV, and conditional write-back.
module alu_op_sequencer #(
  parameter int W    = 8,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rn,
  input  logic [AW-1:0] cmd_rm,
  input  logic          cmd_imm_en,
  input  logic [W-1:0]  cmd_imm,
  input  logic [3:0]    cmd_cond,
  input  logic          cmd_s,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_i,
  input  logic [W-1:0]  alu_f,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          alu_z,
  input  logic          alu_n,
  output logic          done_valid,
  output logic          done_executed,
  output logic [3:0]    flags_nzcv,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                 state;
  logic [NREG-1:0][W-1:0] rf;
  logic [AW-1:0]          rd_q;
  logic [3:0]             cond_q;
  logic                   s_q;
  logic [W-1:0]           res_q;
  logic [3:0]             alu_nzcv_q;
  logic                   cond_pass;

  function automatic logic [W-1:0] rf_read(input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : rf[addr];
  endfunction

  assign cmd_ready = (state == IDLE);
  assign dbg_data  = rf_read(dbg_addr);

  // Flags only change at the end of WB, so EXEC sees the architectural NZCV.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_nzcv;
    cond_pass = 1'b0;
    case (cond_q)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rf            <= '0;
      rd_q          <= '0;
      cond_q        <= '0;
      s_q           <= 1'b0;
      res_q         <= '0;
      alu_nzcv_q    <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_i         <= '0;
      done_valid    <= 1'b0;
      done_executed <= 1'b0;
      flags_nzcv    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_valid    <= 1'b0;
          done_executed <= 1'b0;
          if (cmd_valid) begin
            rd_q   <= cmd_rd;
            cond_q <= cmd_cond;
            s_q    <= cmd_s;
            alu_a  <= rf_read(cmd_rn);
            alu_b  <= cmd_imm_en ? cmd_imm : rf_read(cmd_rm);
            alu_i  <= cmd_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q         <= alu_f;
          alu_nzcv_q    <= {alu_n, alu_z, alu_c, alu_v};
          done_valid    <= 1'b1;
          done_executed <= cond_pass;
          state         <= WB;
        end
        WB: begin
          if (done_executed) begin
            if (rd_q != '0) rf[rd_q] <= res_q;
            // Arithmetic ops own C/V; logical ops leave them untouched.
            if (s_q)
              flags_nzcv <= (alu_i < 3'd3) ? alu_nzcv_q
                                           : {alu_nzcv_q[3:2], flags_nzcv[1:0]};
          end
          done_valid    <= 1'b0;
          done_executed <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural 8-bit ALU, vector table with a
// scoreboard queue, plus hand-written reset and hold sequences.
module tb_alu_op_sequencer;

  localparam int W = 8, NREG = 8, AW = 3;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic          cmd_imm_en = 1'b0;
  logic [W-1:0]  cmd_imm = '0;
  logic [3:0]    cmd_cond = '0;
  logic          cmd_s = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_f;
  logic [2:0]    alu_i;
  logic          alu_c, alu_v, alu_z, alu_n;
  logic          done_valid, done_executed;
  logic [3:0]    flags_nzcv;
  logic [AW-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  int checks = 0, errors = 0;

  alu_op_sequencer #(.W(W), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_cond(cmd_cond), .cmd_s(cmd_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_i(alu_i), .alu_f(alu_f),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .done_valid(done_valid), .done_executed(done_executed), .flags_nzcv(flags_nzcv),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU; subtraction C is the borrow out.
  always_comb begin
    logic [W:0] t;
    t = '0; alu_c = 1'b0; alu_v = 1'b0;
    case (alu_i)
      3'd0: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_c = t[W];
                  alu_v = (alu_a[W-1] == alu_b[W-1]) && (t[W-1] != alu_a[W-1]); end
      3'd1: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_c = t[W];
                  alu_v = (alu_a[W-1] != alu_b[W-1]) && (t[W-1] != alu_a[W-1]); end
      3'd2: begin t = {1'b0, alu_b} - {1'b0, alu_a}; alu_c = t[W];
                  alu_v = (alu_a[W-1] != alu_b[W-1]) && (t[W-1] != alu_b[W-1]); end
      3'd3: t = {1'b0, alu_a & ~alu_b};
      3'd4: t = {1'b0, alu_a & alu_b};
      3'd5: t = {1'b0, alu_a | alu_b};
      3'd6: t = {1'b0, alu_a ^ alu_b};
      default: t = {1'b0, ~(alu_a ^ alu_b)};
    endcase
    alu_f = t[W-1:0];
    alu_z = (alu_f == '0);
    alu_n = alu_f[W-1];
  end

  typedef struct {
    logic [2:0] op; logic [AW-1:0] rd, rn, rm; logic imm_en; logic [W-1:0] imm;
    logic [3:0] cond; logic s; logic hold;
    logic exp_exec; logic [W-1:0] exp_val; logic [3:0] exp_nzcv;
  } vec_t;

  vec_t tbl[20];
  vec_t sb[$];

  function automatic vec_t mk(input logic [2:0] op, input int rd, rn, rm, input logic ie,
                              input logic [7:0] imm, input logic [3:0] cond, input logic s,
                              input logic hold, input logic ex, input logic [7:0] val,
                              input logic [3:0] nzcv);
    vec_t v;
    v.op = op; v.rd = AW'(rd); v.rn = AW'(rn); v.rm = AW'(rm); v.imm_en = ie; v.imm = imm;
    v.cond = cond; v.s = s; v.hold = hold; v.exp_exec = ex; v.exp_val = val; v.exp_nzcv = nzcv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int lat;
    vec_t e;
    @(negedge clk);
    cmd_op = v.op; cmd_rd = v.rd; cmd_rn = v.rn; cmd_rm = v.rm; cmd_imm_en = v.imm_en;
    cmd_imm = v.imm; cmd_cond = v.cond; cmd_s = v.s; cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 10) begin @(negedge clk); lat++; end
    check($sformatf("ready_before_accept[%0d]", idx), cmd_ready, 1);
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    lat = 1;
    check($sformatf("busy_in_exec[%0d]", idx), cmd_ready, 0);
    if (!v.hold) cmd_valid = 1'b0;
    while (!done_valid && lat < 8) begin @(negedge clk); lat++; end
    check($sformatf("done_latency[%0d]", idx), lat, 2);
    if (v.hold) check($sformatf("busy_in_wb[%0d]", idx), cmd_ready, 0);
    cmd_valid = 1'b0;
    e = sb.pop_front();
    check($sformatf("done_executed[%0d]", idx), done_executed, e.exp_exec);
    @(negedge clk);
    check($sformatf("done_pulse_end[%0d]", idx), done_valid, 0);
    check($sformatf("flags[%0d]", idx), flags_nzcv, e.exp_nzcv);
    dbg_addr = e.rd;
    #1;
    check($sformatf("rf_rd[%0d]", idx), dbg_data, e.exp_val);
  endtask

  initial begin
    int seen;
    //          op     rd rn rm ie imm    cond   s  hold ex val    nzcv
    tbl[0]  = mk(3'd5, 1, 0, 0, 1, 8'h7F, 4'hE, 0, 0, 1, 8'h7F, 4'b0000);
    tbl[1]  = mk(3'd5, 2, 0, 0, 1, 8'h01, 4'hE, 0, 0, 1, 8'h01, 4'b0000);
    tbl[2]  = mk(3'd0, 3, 1, 2, 0, 8'h00, 4'hE, 1, 0, 1, 8'h80, 4'b1001);
    tbl[3]  = mk(3'd1, 4, 2, 2, 0, 8'h00, 4'hE, 1, 0, 1, 8'h00, 4'b0100);
    tbl[4]  = mk(3'd5, 5, 0, 0, 1, 8'hAA, 4'h1, 0, 0, 0, 8'h00, 4'b0100);
    tbl[5]  = mk(3'd5, 5, 0, 0, 1, 8'hAA, 4'h0, 0, 0, 1, 8'hAA, 4'b0100);
    tbl[6]  = mk(3'd0, 3, 1, 2, 0, 8'h00, 4'hE, 1, 0, 1, 8'h80, 4'b1001);
    tbl[7]  = mk(3'd4, 6, 1, 0, 1, 8'h0F, 4'hE, 1, 0, 1, 8'h0F, 4'b0001);
    tbl[8]  = mk(3'd5, 0, 0, 0, 1, 8'hFF, 4'hE, 0, 1, 1, 8'h00, 4'b0001);
    tbl[9]  = mk(3'd2, 7, 2, 1, 0, 8'h00, 4'hE, 1, 0, 1, 8'h7E, 4'b0000);
    tbl[10] = mk(3'd6, 7, 7, 0, 1, 8'hFF, 4'hA, 1, 0, 1, 8'h81, 4'b1000);
    tbl[11] = mk(3'd7, 6, 7, 0, 1, 8'h81, 4'hB, 0, 0, 1, 8'hFF, 4'b1000);
    tbl[12] = mk(3'd3, 5, 6, 0, 1, 8'h0F, 4'h4, 1, 0, 1, 8'hF0, 4'b1000);
    tbl[13] = mk(3'd0, 4, 6, 0, 1, 8'h01, 4'hE, 1, 1, 1, 8'h00, 4'b0110);
    tbl[14] = mk(3'd5, 4, 0, 0, 1, 8'h55, 4'h8, 0, 0, 0, 8'h00, 4'b0110);
    tbl[15] = mk(3'd5, 4, 0, 0, 1, 8'h55, 4'h9, 0, 0, 1, 8'h55, 4'b0110);
    tbl[16] = mk(3'd5, 4, 0, 0, 1, 8'h11, 4'hF, 0, 0, 0, 8'h55, 4'b0110);
    tbl[17] = mk(3'd1, 3, 0, 0, 1, 8'h01, 4'hE, 1, 0, 1, 8'hFF, 4'b1010);
    tbl[18] = mk(3'd5, 2, 0, 0, 1, 8'h3C, 4'h2, 0, 0, 1, 8'h3C, 4'b1010);
    tbl[19] = mk(3'd5, 2, 0, 0, 1, 8'h99, 4'h3, 0, 0, 0, 8'h3C, 4'b1010);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_flags", flags_nzcv, 0);
    check("reset_alu_i", alu_i, 0);
    check("reset_done_valid", done_valid, 0);
    for (int a = 0; a < NREG; a++) begin
      dbg_addr = AW'(a);
      #1;
      check($sformatf("reset_rf[%0d]", a), dbg_data, 0);
    end

    for (int i = 0; i < 20; i++) run_cmd(tbl[i], i);

    // Held cmd_valid (tbl[8], tbl[13]) must not produce a second acceptance.
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    check("no_reaccept_after_hold", seen, 0);

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    cmd_op = 3'd0; cmd_rd = 3'd7; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_imm_en = 1'b0;
    cmd_cond = 4'hE; cmd_s = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_exec", cmd_ready, 0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_async_ready", cmd_ready, 1);
    check("abort_async_done", done_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_flags", flags_nzcv, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_alu_i", alu_i, 0);
    dbg_addr = 3'd7;
    #1;
    check("abort_r7", dbg_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
